// File: rtl/instruction_sequencer.sv
// Four-phase instruction sequencer with instruction register, group decode,
// PC-increment pulse, retired-instruction counter and halt state.
module instruction_sequencer #(
    parameter int          COUNT_WIDTH = 16,
    parameter logic [15:0] RESET_IR    = 16'h0000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [15:0]            DATA_IN,
    input  logic                   DATA_VALID,
    input  logic                   HOLD,
    input  logic                   HALT_REQ,
    output logic                   MEM_RD,
    output logic                   FETCH,
    output logic                   DECODE,
    output logic                   EXECUTE,
    output logic                   COMMIT,
    output logic [13:0]            INSTRUCTION,
    output logic [1:0]             GROUP,
    output logic                   GRP_SYS,
    output logic                   GRP_LDS,
    output logic                   GRP_JMP,
    output logic                   GRP_ALU,
    output logic                   PC_INC,
    output logic [COUNT_WIDTH-1:0] RETIRED,
    output logic                   HALTED
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_COMMIT,
        S_HALTED
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            ir;
    logic [COUNT_WIDTH-1:0] retired;
    logic                   grp_en;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_FETCH;
            ir      <= RESET_IR;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && DATA_VALID)
                ir <= DATA_IN;
            if (state == S_COMMIT)
                retired <= retired + ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        FETCH     = 1'b0;
        DECODE    = 1'b0;
        EXECUTE   = 1'b0;
        COMMIT    = 1'b0;
        HALTED    = 1'b0;
        unique case (state)
            S_FETCH: begin
                FETCH = 1'b1;
                if (DATA_VALID)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                DECODE    = 1'b1;
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                EXECUTE = 1'b1;
                if (!HOLD)
                    state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                COMMIT    = 1'b1;
                state_nxt = HALT_REQ ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                HALTED = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Group enables only while an instruction is resident past fetch.
    assign grp_en      = DECODE | EXECUTE | COMMIT;
    assign MEM_RD      = FETCH;
    assign PC_INC      = COMMIT;
    assign INSTRUCTION = ir[13:0];
    assign GROUP       = ir[15:14];
    assign GRP_SYS     = grp_en && (ir[15:14] == 2'b00);
    assign GRP_LDS     = grp_en && (ir[15:14] == 2'b01);
    assign GRP_JMP     = grp_en && (ir[15:14] == 2'b10);
    assign GRP_ALU     = grp_en && (ir[15:14] == 2'b11);
    assign RETIRED     = retired;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: instruction-level model,
// two instances (16-bit and 4-bit retired counter) sharing inputs.
module tb_instruction_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        HOLD;
    logic        HALT_REQ;

    logic        mem_rd_a, fetch_a, decode_a, execute_a, commit_a;
    logic [13:0] instr_a;
    logic [1:0]  group_a;
    logic        sys_a, lds_a, jmp_a, alu_a, pcinc_a, halted_a;
    logic [15:0] retired_a;

    logic        mem_rd_b, fetch_b, decode_b, execute_b, commit_b;
    logic [13:0] instr_b;
    logic [1:0]  group_b;
    logic        sys_b, lds_b, jmp_b, alu_b, pcinc_b, halted_b;
    logic [3:0]  retired_b;

    int vectors = 0;
    int miscompares = 0;

    int          m_ret;
    logic [15:0] m_ir;

    always #5 CLK = ~CLK;

    instruction_sequencer #(.COUNT_WIDTH(16), .RESET_IR(16'h0000)) dut_a (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID), .HOLD(HOLD), .HALT_REQ(HALT_REQ),
        .MEM_RD(mem_rd_a), .FETCH(fetch_a), .DECODE(decode_a),
        .EXECUTE(execute_a), .COMMIT(commit_a),
        .INSTRUCTION(instr_a), .GROUP(group_a),
        .GRP_SYS(sys_a), .GRP_LDS(lds_a), .GRP_JMP(jmp_a), .GRP_ALU(alu_a),
        .PC_INC(pcinc_a), .RETIRED(retired_a), .HALTED(halted_a)
    );

    instruction_sequencer #(.COUNT_WIDTH(4), .RESET_IR(16'h0000)) dut_b (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID), .HOLD(HOLD), .HALT_REQ(HALT_REQ),
        .MEM_RD(mem_rd_b), .FETCH(fetch_b), .DECODE(decode_b),
        .EXECUTE(execute_b), .COMMIT(commit_b),
        .INSTRUCTION(instr_b), .GROUP(group_b),
        .GRP_SYS(sys_b), .GRP_LDS(lds_b), .GRP_JMP(jmp_b), .GRP_ALU(alu_b),
        .PC_INC(pcinc_b), .RETIRED(retired_b), .HALTED(halted_b)
    );

    // Phase codes used by the model: 0 fetch, 1 decode, 2 execute, 3 commit, 4 halted
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic noise;
        DATA_IN    = 16'($urandom);
        DATA_VALID = 1'($urandom);
        HOLD       = 1'($urandom);
        HALT_REQ   = 1'($urandom);
    endtask

    task automatic check(input string tag, input int phase);
        logic [26:0] obs_a, obs_b, exp_v;
        logic [3:0]  g;
        logic [15:0] exp_ra;
        logic [3:0]  exp_rb;
        g = 4'b0000;
        if (phase >= 1 && phase <= 3)
            g = 4'b0001 << m_ir[15:14];
        exp_v = {phase == 0, phase == 0, phase == 1, phase == 2, phase == 3,
                 m_ir[13:0], m_ir[15:14], g, phase == 3, phase == 4};
        obs_a = {mem_rd_a, fetch_a, decode_a, execute_a, commit_a, instr_a,
                 group_a, alu_a, jmp_a, lds_a, sys_a, pcinc_a, halted_a};
        obs_b = {mem_rd_b, fetch_b, decode_b, execute_b, commit_b, instr_b,
                 group_b, alu_b, jmp_b, lds_b, sys_b, pcinc_b, halted_b};
        exp_ra = 16'(m_ret % 65536);
        exp_rb = 4'(m_ret % 16);
        vectors++;
        assert (obs_a === exp_v) else begin
            miscompares++;
            $error("FAIL %s outputs obs=%h exp=%h", tag, obs_a, exp_v);
        end
        vectors++;
        assert (obs_b === exp_v) else begin
            miscompares++;
            $error("FAIL %s outputs4 obs=%h exp=%h", tag, obs_b, exp_v);
        end
        vectors++;
        assert (retired_a === exp_ra) else begin
            miscompares++;
            $error("FAIL %s retired obs=%0d exp=%0d", tag, retired_a, exp_ra);
        end
        vectors++;
        assert (retired_b === exp_rb) else begin
            miscompares++;
            $error("FAIL %s retired4 obs=%0d exp=%0d", tag, retired_b, exp_rb);
        end
    endtask

    task automatic do_reset(input int cycles);
        noise();
        RESET = 1'b1;
        for (int i = 0; i < cycles; i++)
            tick();
        RESET = 1'b0;
        m_ir  = 16'h0000;
        m_ret = 0;
        check("reset", 0);
    endtask

    // One instruction: nwait idle fetch cycles, nhold stall cycles.
    // abort_exec asserts RESET in the first execute cycle instead of finishing.
    task automatic run_instr(input logic [15:0] word, input int nwait,
                             input int nhold, input bit halt,
                             input bit abort_exec);
        for (int i = 0; i < nwait; i++) begin
            check("fetch_wait", 0);
            noise();
            DATA_VALID = 1'b0;
            tick();
        end
        check("fetch", 0);
        noise();
        DATA_VALID = 1'b1;
        DATA_IN    = word;
        tick();
        m_ir = word;
        check("decode", 1);
        noise();
        tick();
        if (abort_exec) begin
            check("exec_abort", 2);
            noise();
            RESET = 1'b1;
            tick();
            RESET = 1'b0;
            m_ir  = 16'h0000;
            m_ret = 0;
            check("after_abort", 0);
            return;
        end
        for (int i = 0; i < nhold; i++) begin
            check("exec_hold", 2);
            noise();
            HOLD = 1'b1;
            tick();
        end
        check("execute", 2);
        noise();
        HOLD = 1'b0;
        tick();
        check("commit", 3);
        noise();
        HALT_REQ = halt;
        tick();
        m_ret++;
        if (halt) begin
            for (int i = 0; i < 20; i++) begin
                check("halted", 4);
                noise();
                tick();
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        RESET      = 1'b1;
        DATA_IN    = '0;
        DATA_VALID = 1'b0;
        HOLD       = 1'b0;
        HALT_REQ   = 1'b0;

        do_reset(2);
        run_instr(16'hC123, 0, 0, 1'b0, 1'b0);
        run_instr(16'h4ABC, 3, 0, 1'b0, 1'b0);
        run_instr(16'h8F0F, 0, 5, 1'b1, 1'b0);

        do_reset(1);
        run_instr(16'h1234, 1, 1, 1'b0, 1'b0);
        run_instr(16'hC555, 0, 0, 1'b0, 1'b1);
        run_instr(16'h7777, 0, 2, 1'b0, 1'b0);

        // Counter wrap on the 4-bit instance, group-patterned words
        do_reset(1);
        for (int n = 0; n < 18; n++) begin
            w = 16'($urandom) & 16'h3FFF;
            w = w | (16'(n % 4) << 14);
            run_instr(w, 0, 0, 1'b0, 1'b0);
        end

        // Randomized traffic, occasional halt followed by reset
        for (int n = 0; n < 150; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                          1'b1, 1'b0);
                do_reset($urandom_range(1, 2));
            end else if ($urandom_range(0, 29) == 0) begin
                run_instr(w, $urandom_range(0, 3), 0, 1'b0, 1'b1);
            end else begin
                run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                          1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Four-phase instruction sequencer and instruction register sitting directly upstream of the per-group decoders (ALU, load/store, jump, system). It fetches a 16-bit instruction word from the memory read path and holds it stable for the rest of the instruction. It generates the one-hot FETCH/DECODE/EXECUTE/COMMIT phase strobes, the 14-bit INSTRUCTION field and a one-hot group enable. It also supplies the PC-increment pulse, a retired-instruction counter and a halt state.

## Interface
Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- RESET_IR, 16'h0000, instruction register value after reset (group 0 / system, all fields zero).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  16  memory read data; sampled only in FETCH.
- DATA_VALID  in  1  memory read acknowledge; ignored outside FETCH.
- HOLD  in  1  stall request; honoured only in EXECUTE.
- HALT_REQ  in  1  halt request; sampled only in COMMIT.
- MEM_RD  out  1  instruction read request; equals FETCH.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase strobes.
- INSTRUCTION  out  14  IR[13:0] to the group decoders.
- GROUP  out  2  IR[15:14] (GPF).
- GRP_SYS, GRP_LDS, GRP_JMP, GRP_ALU  out  1 each  one-hot decode of GROUP (00, 01, 10, 11).
- PC_INC  out  1  one-cycle pulse in COMMIT.
- RETIRED  out  COUNT_WIDTH  count of completed instructions.
- HALTED  out  1  high while in HALTED state.

## Operation
- FSM states: S_FETCH, S_DECODE, S_EXECUTE, S_COMMIT, S_HALTED. Encoding is free; outputs are Moore, decoded from state and registers only.
- S_FETCH: FETCH=MEM_RD=1.
  - DATA_VALID=1: IR<=DATA_IN, next S_DECODE.
  - Otherwise stay, IR unchanged.
- S_DECODE: DECODE=1; unconditional next S_EXECUTE.
- S_EXECUTE: EXECUTE=1; HOLD=1 stays, HOLD=0 next S_COMMIT.
- S_COMMIT: COMMIT=1, PC_INC=1, RETIRED<=RETIRED+1 (modulo 2^COUNT_WIDTH, wraps all-ones to 0).
  - HALT_REQ=1: next S_HALTED.
  - Otherwise next S_FETCH.
- S_HALTED: all phase strobes, MEM_RD and PC_INC are 0; HALTED=1. IR and RETIRED hold. Only RESET exits.
- Group enables: GRP_* is the one-hot decode of GROUP, gated to 0 in S_FETCH and S_HALTED. Exactly one is high in DECODE/EXECUTE/COMMIT.
- INSTRUCTION and GROUP always reflect IR. They are stable from the first DECODE cycle through COMMIT, and change only on the FETCH cycle that sees DATA_VALID.
- Inputs not listed for the current state have no effect (e.g. HOLD in FETCH, DATA_VALID in EXECUTE, HALT_REQ outside COMMIT).

## Timing
- Reset, on the edge where RESET=1:
  - State becomes S_FETCH; IR<=RESET_IR; RETIRED<=0.
  - Outputs after that edge: FETCH=MEM_RD=1, other strobes 0, GRP_* all 0, PC_INC=0, HALTED=0, INSTRUCTION=RESET_IR[13:0], GROUP=RESET_IR[15:14].
  - RESET overrides every other input in every state, including mid-instruction and in S_HALTED. An aborted instruction does not increment RETIRED.
- Minimum instruction length is 4 cycles: FETCH (DATA_VALID already high), DECODE, EXECUTE, COMMIT. Back-to-back instructions run with no idle cycle.
- Each FETCH cycle with DATA_VALID=0 adds one cycle; each EXECUTE cycle with HOLD=1 adds one cycle.
- RETIRED shows the new value in the cycle after COMMIT.
- Exactly one of FETCH/DECODE/EXECUTE/COMMIT/HALTED is high every cycle after reset.

## Test plan
- Reset and single instruction:
  - Stimulus: hold RESET 2 cycles, release; DATA_VALID=1 with DATA_IN=16'hC123, HOLD=0.
  - Required: phases F,D,E,C on consecutive cycles; INSTRUCTION=14'h0123, GROUP=3, GRP_ALU=1 only in D/E/C; PC_INC once; RETIRED=1.
- Fetch wait:
  - Stimulus: DATA_VALID low 3 cycles, then high with 16'h4ABC.
  - Required: FETCH high 4 cycles; IR unchanged until the 4th cycle; then GRP_LDS=1, INSTRUCTION=14'h0ABC.
- Execute stall:
  - Stimulus: HOLD=1 for 5 cycles from the first EXECUTE cycle.
  - Required: EXECUTE high 6 cycles, COMMIT on the 7th; INSTRUCTION stable throughout; DATA_VALID pulses during the stall are ignored.
- Halt:
  - Stimulus: HALT_REQ=1 only during COMMIT of the 3rd instruction.
  - Required: HALTED=1 thereafter; strobes 0; RETIRED=3 and held for 20 cycles; RESET returns to FETCH with RETIRED=0.
- Reset mid-instruction:
  - Stimulus: RESET during EXECUTE of the 2nd instruction.
  - Required: RETIRED=0, IR=RESET_IR, FETCH=1 on the next cycle, no PC_INC.
- Counter wrap:
  - Stimulus: COUNT_WIDTH=4, run 17 instructions.
  - Required: RETIRED sequence ...,14,15,0,1; group enables track 16'h0000/4000/8000/C000 words as GRP_SYS/LDS/JMP/ALU.
